// File: rtl/register10bit.sv
// Generic WIDTH-bit holding register with an asynchronous active-low clear.
// It captures data_in on every rising clk edge and drives data_out straight from the flops.
module register10bit #(
  parameter int unsigned WIDTH = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // There is no enable: every edge out of reset reloads, even if data_in is unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= RESET_VALUE;
    end else begin
      data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_register10bit.sv
// Directed self-checking bench for register10bit.
// It covers capture latency, asynchronous clear, hold in reset, reset release, glitch immunity and a vector table.
module tb_register10bit;

  logic       clk;
  logic       rst;
  logic [9:0] data_in;
  logic [9:0] data_out;

  int checks;
  int errors;

  // Each entry is {rst, data_in}. The expected output after the edge is data_in if rst=1, and zero otherwise.
  logic [10:0] vecs [0:19] = '{
    11'h4AA, 11'h555, 11'h0FF, 11'h7FF, 11'h400,
    11'h401, 11'h200, 11'h6C3, 11'h53C, 11'h13C,
    11'h5A5, 11'h65A, 11'h000, 11'h7FE, 11'h480,
    11'h37F, 11'h4F0, 11'h40F, 11'h2AA, 11'h555
  };

  register10bit dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change only on the falling edge, well away from the capturing edge.
  task automatic applyStimulus(input logic rstVal, input logic [9:0] dataVal);
    @(negedge clk);
    rst     = rstVal;
    data_in = dataVal;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       vRst;
    logic [9:0] vData;
    logic [9:0] expected;
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    data_in = 10'h000;
    #1;
    checkOutput("reset_initial", data_out, 10'h000);

    applyStimulus(1'b1, 10'h2AA);
    afterEdge();
    checkOutput("capture_2AA", data_out, 10'h2AA);
    applyStimulus(1'b1, 10'h155);
    #1;
    checkOutput("no_update_before_edge", data_out, 10'h2AA);
    afterEdge();
    checkOutput("capture_155", data_out, 10'h155);

    applyStimulus(1'b1, 10'h3FF);
    afterEdge();
    checkOutput("capture_3FF", data_out, 10'h3FF);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clear_midcycle", data_out, 10'h000);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? 10'h155 : 10'h2AA);
      afterEdge();
      checkOutput("hold_in_reset", data_out, 10'h000);
    end

    @(negedge clk);
    data_in = 10'h2C7;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("release_no_immediate_change", data_out, 10'h000);
    afterEdge();
    checkOutput("release_first_capture", data_out, 10'h2C7);

    applyStimulus(1'b1, 10'h001);
    afterEdge();
    checkOutput("capture_001", data_out, 10'h001);
    #1 data_in = 10'h3FE;
    #2 data_in = 10'h001;
    #1;
    checkOutput("glitch_between_edges", data_out, 10'h001);
    afterEdge();
    checkOutput("glitch_after_edge", data_out, 10'h001);

    // A short reset pulse between edges still clears, and the register stays clear until the next edge.
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("short_pulse_clear", data_out, 10'h000);
    data_in = 10'h13A;
    afterEdge();
    checkOutput("short_pulse_reload", data_out, 10'h13A);

    for (int i = 0; i < 20; i++) begin
      vRst  = vecs[i][10];
      vData = vecs[i][9:0];
      expected = vRst ? vData : 10'h000;
      applyStimulus(vRst, vData);
      afterEdge();
      checkOutput($sformatf("vector_%0d", i), data_out, expected);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
